// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction ROM port, execute redirect, decode handshake.
// FETCH_ALIGN_CHECK_EN adds the fetch_fault signal.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    output fetch_fault,
`endif
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    input  fetch_fault,
`endif
    input  out_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, buffers {pc, instr} pairs for decode, flushes on redirect.
// Define FETCH_ALIGN_CHECK_EN to halt with fetch_fault on a misaligned redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic [31:0]     r_pc;
  ptr_t            r_rd;
  ptr_t            r_wr;
  logic [CntW-1:0] r_count;
  logic [31:0]     r_entry_pc    [DEPTH];
  logic [31:0]     r_entry_instr [DEPTH];

  logic w_halted;
  logic w_redirect;
  logic w_push;
  logic w_pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_halted;

  // Fault is sticky; only reset clears it, later redirects are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (w_redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted        = r_halted;
  assign bus.fetch_fault = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  assign w_redirect = bus.redirect_valid && !w_halted;
  // A full buffer blocks push even when decode pops in the same cycle.
  assign w_push     = !bus.redirect_valid && (r_count < CntW'(DEPTH)) && !w_halted;
  assign w_pop      = bus.out_valid && bus.out_ready;

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_pc    = r_entry_pc[r_rd];
  assign bus.out_instr = r_entry_instr[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entry_pc[i]    <= '0;
        r_entry_instr[i] <= '0;
      end
    end else if (w_redirect) begin
      r_pc    <= {bus.redirect_pc[31:2], 2'b00};
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_entry_pc[r_wr]    <= r_pc;
        r_entry_instr[r_wr] <= bus.imem_data;
        r_wr                <= r_wr + ptr_t'(1);
        r_pc                <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd <= r_rd + ptr_t'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
// Builds with or without FETCH_ALIGN_CHECK_EN.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  assign bus.imem_data = rom(bus.imem_addr);

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs currently driven.
  function automatic void model_edge();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (reset) begin
      model_reset();
      return;
    end
    if (bus.redirect_valid) begin
      if (m_fault) return;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
`endif
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      m_q.delete();
      return;
    end
    do_pop  = (m_q.size() != 0) && bus.out_ready;
    do_push = (m_q.size() < DEPTH) && !m_fault;
    e.pc    = m_pc;
    e.instr = rom(m_pc);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
    check_eq({tag, ".addr"}, bus.imem_addr, m_pc);
    if (m_q.size() != 0) begin
      check_eq({tag, ".pc"}, bus.out_pc, m_q[0].pc);
      check_eq({tag, ".instr"}, bus.out_instr, m_q[0].instr);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq({tag, ".fault"}, {31'd0, bus.fetch_fault}, {31'd0, m_fault});
`endif
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rpc);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();
    #2;
    check_eq("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst.addr", bus.imem_addr, RESET_PC);
    check_eq("rst.pc", bus.out_pc, 32'd0);
    check_eq("rst.instr", bus.out_instr, 32'd0);
    step("rst_hold", 1'b0, 1'b0, '0);
    reset = 1'b0;

    // Fill with decode stalled: two entries, PC held at 8.
    step("fill0", 1'b0, 1'b0, '0);
    check_eq("fill0.first_pc", bus.out_pc, RESET_PC);
    step("fill1", 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step("stall", 1'b0, 1'b0, '0);
    check_eq("stall.addr_held", bus.imem_addr, 32'd8);

    // Release backpressure, then free run one per cycle.
    for (int i = 0; i < 8; i++) step("run", 1'b1, 1'b0, '0);

    // Redirect while full with decode ready.
    for (int i = 0; i < 3; i++) step("prefill", 1'b0, 1'b0, '0);
    step("redir", 1'b1, 1'b1, 32'h40);
    check_eq("redir.empty", {31'd0, bus.out_valid}, 32'd0);
    step("redir_t0", 1'b1, 1'b0, '0);
    check_eq("redir.target", bus.out_pc, 32'h40);
    step("redir_t1", 1'b1, 1'b0, '0);
    check_eq("redir.next", bus.out_pc, 32'h44);

    // Back-to-back redirects: last one wins.
    step("b2b0", 1'b1, 1'b1, 32'h100);
    step("b2b1", 1'b1, 1'b1, 32'h203);
    step("b2b2", 1'b1, 1'b0, '0);

    // Async reset between edges.
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst.pc", bus.out_pc, 32'd0);
    step("async_hold", 1'b1, 1'b0, '0);
    reset = 1'b0;
    step("restart", 1'b1, 1'b0, '0);

`ifdef FETCH_ALIGN_CHECK_EN
    step("align_run", 1'b1, 1'b0, '0);
    step("misalign", 1'b1, 1'b1, 32'h42);
    check_eq("misalign.fault", {31'd0, bus.fetch_fault}, 32'd1);
    check_eq("misalign.addr", bus.imem_addr, 32'h40);
    for (int i = 0; i < 3; i++) step("halted", 1'b1, 1'b0, '0);
    step("ignored", 1'b1, 1'b1, 32'h80);
    check_eq("ignored.addr", bus.imem_addr, 32'h40);
    step("ignored1", 1'b1, 1'b0, '0);
    reset = 1'b1;
    step("align_rst", 1'b1, 1'b0, '0);
    reset = 1'b0;
`endif

    // Random traffic: ready, redirects, occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] tgt;
      rdy = ($urandom_range(3, 0) != 0);
      rv  = ($urandom_range(9, 0) == 0);
      tgt = $urandom() & 32'h0000_0FFC;
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(15, 0) == 0) tgt = tgt | 32'd2;
`endif
      reset = ($urandom_range(39, 0) == 0);
      step("rand", rdy, rv, tgt);
    end
    reset = 1'b0;
    step("final", 1'b1, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage placed directly upstream of simple_memory (combinational, word-addressed instruction ROM).
- Owns the program counter and drives the ROM address.
- Captures the returned instruction word with its PC into a small FIFO.
- Presents entries to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute and flushes stale entries.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
imem_addr  output  32  byte address to simple_memory; equals current PC
imem_data  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  32  redirect target byte address
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_pc  output  32  PC of head instruction
out_instr  output  32  head instruction word
fetch_fault  output  1  only when FETCH_ALIGN_CHECK_EN defined: misaligned redirect seen

Behaviour:
- Reset (async assert, all state): pc=RESET_PC, count=0, rd/wr pointers=0, out_valid=0, out_pc=0, out_instr=0, fetch_fault=0.
- imem_addr = pc register, combinational; no other logic on the path.
- push = !redirect_valid && (count < DEPTH) && !halted. On push, entry[wr]={pc, imem_data}, wr++, pc<=pc+4 (mod 2^32, wraps silently).
- pop = out_valid && out_ready. On pop, rd++.
- Full buffer blocks push even if a pop occurs the same cycle. pc and imem_addr hold while blocked.
- count update: +1 push only, -1 pop only, unchanged for both or neither.
- out_valid = (count != 0). out_pc/out_instr = entry[rd], registered storage. When empty, they hold their last value.
- Latency: first clock edge after reset deassertion pushes RESET_PC. out_valid=1 from that edge. Steady-state throughput is 1 instr/cycle with out_ready=1.
- Redirect (redirect_valid=1) has priority over push and pop bookkeeping:
  - pc <= {redirect_pc[31:2], 2'b00}; count, rd, wr <= 0; no push.
  - out_valid=0 the next cycle.
  - A pop handshake in the redirect cycle still counts as accepted by decode.
  - The following cycle fetches the target.
  - Back-to-back redirects: the last one wins, and nothing is pushed until redirect_valid drops.
- Reset asserted mid-operation: immediate return to reset state, buffer contents discarded.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: fetch_fault port exists.
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault=1 (sticky until reset) and sets halted.
  - While halted: no pushes, pc frozen at the masked target, buffer flushed as for a normal redirect.
  - Later redirects while halted are ignored.
- Undefined: no fetch_fault port, halted is constant 0, and low two target bits are silently masked to zero.

Test Plan:
- Reset with RESET_PC=0, out_ready=0 -> out_valid=0, imem_addr=0. After release, two edges fill the buffer: count=2, imem_addr=8 held.
- Free run, out_ready=1, ROM word n = 0x1000+n -> out_pc sequence 0,4,8,12 with out_instr 0x1000..0x1003, one per cycle, no bubbles.
- Backpressure: ready=0 for 5 cycles then 1 -> exactly entries pc 0,4 buffered, no drop or duplicate, then 8 follows immediately.
- Redirect to 0x40 while buffer full and out_ready=1 -> next cycle out_valid=0. Following cycle out_pc=0x40, then 0x44. Pre-redirect entries never reappear.
- Async reset asserted between clock edges mid-stream -> outputs reach reset values before the next edge. Fetch restarts at RESET_PC.
- With FETCH_ALIGN_CHECK_EN defined, redirect to 0x42 -> fetch_fault=1 next cycle, out_valid stays 0, imem_addr=0x40 frozen. A later redirect to 0x80 is ignored until reset.
